// File: rtl/riscv_io_pkg.sv
// riscv_io_pkg: shared address map, STATUS bit layout and UART FSM encoding for MEM-stage I/O.
package riscv_io_pkg;
    localparam logic [31:0] UART_BASE_ADDR = 32'h1000_0000;
    localparam logic [2:0]  TXDATA_OFS     = 3'h0;
    localparam logic [2:0]  STATUS_OFS     = 3'h4;
    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/riscv_mmio_uart_tx.sv
// riscv_mmio_uart_tx: MEM-stage memory-mapped 8N1 UART transmitter with TX FIFO and sticky overflow.
module riscv_mmio_uart_tx
    import riscv_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = UART_BASE_ADDR,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ALU_result_M,
    input  logic [31:0] WriteData_M,
    input  logic        MemWrite_M,
    output logic        hit_M,
    output logic [31:0] ReadData_io,
    output logic        tx,
    output logic        busy
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    uart_state_t state, state_nxt;
    logic [BW-1:0] baud;
    logic [2:0] bit_cnt;
    logic [7:0] shreg, shreg_nxt, fifo_dout;
    logic [CW-1:0] count;
    logic [31:0] count_w, status;
    logic [3:0] cnt_sat;
    logic tick, push, pop, clr_ovf, is_status, full, empty, ovf, tx_nxt, busy_nxt, unused_bits;
    assign hit_M       = ALU_result_M[31:3] == BASE_ADDR[31:3];
    assign is_status   = {ALU_result_M[2], 2'b00} == STATUS_OFS;
    assign push        = MemWrite_M && hit_M && {ALU_result_M[2], 2'b00} == TXDATA_OFS;
    assign clr_ovf     = MemWrite_M && hit_M && is_status && WriteData_M[3];
    assign pop         = state == IDLE && !empty;
    assign tick        = baud == BW'(CLKS_PER_BIT - 1);
    assign unused_bits = ^{ALU_result_M[1:0], WriteData_M[31:8]};
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(WriteData_M[7:0]),
        .dout(fifo_dout), .full(full), .empty(empty), .count(count)
    );
    always_comb begin
        count_w = 32'(count);
        cnt_sat = count_w > 32'd15 ? 4'hF : count_w[3:0];
        status = '0;
        status[ST_FULL] = full;
        status[ST_EMPTY] = empty;
        status[ST_BUSY] = busy;
        status[ST_OVF] = ovf;
        status[ST_CNT_LSB +: 4] = cnt_sat;
        ReadData_io = (hit_M && is_status) ? status : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_nxt;
            baud    <= (state == IDLE || tick) ? '0 : baud + BW'(1);
            bit_cnt <= state != DATA ? '0 : bit_cnt + 3'(tick);
            shreg   <= shreg_nxt;
            tx      <= tx_nxt;
            busy    <= busy_nxt;
            ovf     <= clr_ovf ? 1'b0 : (push && full && !pop) ? 1'b1 : ovf;
        end
    end
    always_comb begin
        state_nxt = state == IDLE  ? (empty ? IDLE : START) :
                    state == START ? (tick ? DATA : START) :
                    state == DATA  ? ((tick && bit_cnt == 3'd7) ? STOP : DATA) :
                                     (tick ? IDLE : STOP);
    end
    // tx is registered, so it follows the next-cycle shift register contents
    always_comb begin
        shreg_nxt = pop ? fifo_dout : (state == DATA && tick) ? shreg >> 1 : shreg;
        tx_nxt    = state_nxt == DATA ? shreg_nxt[0] : state_nxt != START;
        busy_nxt  = state_nxt != IDLE;
    end
endmodule

// File: tb/tb_riscv_mmio_uart_tx.sv
// tb_riscv_mmio_uart_tx: frame-level reference model compared every cycle, plus literal frame/status checks.
module tb_riscv_mmio_uart_tx;
    localparam int C = 4;
    localparam int D = 4;
    localparam logic [31:0] BASE = 32'h1000_0000;
    logic clk = 1'b0, rst_n = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic hit, tx, busy;
    logic [31:0] rdata;
    int checks = 0, passed = 0, cyc = 0;
    logic txh [8192];
    logic bh [8192];
    logic [7:0] q [$];
    logic [7:0] m_cur;
    bit m_ovf, m_act, popped;
    int m_pos, sz;

    riscv_mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .ALU_result_M(addr), .WriteData_M(wdata), .MemWrite_M(we),
        .hit_M(hit), .ReadData_io(rdata), .tx(tx), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk)
        if (cyc < 8192) begin
            txh[cyc] = tx;
            bh[cyc] = busy;
        end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic logic m_hit();
        return addr[31:3] == BASE[31:3];
    endfunction

    // A frame is {stop=1, data LSB first, start=0}, each bit C cycles long
    function automatic logic m_tx();
        int idx;
        if (!m_act) return 1'b1;
        idx = m_pos / C;
        return idx == 0 ? 1'b0 : idx == 9 ? 1'b1 : m_cur[idx-1];
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s = '0;
        int n = q.size();
        s[0] = n == D;
        s[1] = n == 0;
        s[2] = m_act;
        s[3] = m_ovf;
        s[7:4] = 4'(n > 15 ? 15 : n);
        return s;
    endfunction

    function automatic logic [31:0] exp_rd();
        return (m_hit() && addr[2]) ? m_status() : 32'h0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_ovf = 0;
            m_act = 0;
            m_pos = 0;
        end else begin
            sz = q.size();
            popped = 0;
            if (m_act) begin
                if (m_pos == 10*C-1) m_act = 0;
                else m_pos++;
            end else if (sz > 0) begin
                m_cur = q.pop_front();
                m_act = 1;
                m_pos = 0;
                popped = 1;
            end
            if (we && m_hit() && !addr[2]) begin
                if (sz < D || popped) q.push_back(wdata[7:0]);
                else m_ovf = 1;
            end
            if (we && m_hit() && addr[2] && wdata[3]) m_ovf = 0;
        end
    end

    always @(negedge clk)
        if (rst_n) begin
            chk("tx", 32'(tx), 32'(m_tx()));
            chk("busy", 32'(busy), 32'(m_act));
            chk("hit", 32'(hit), 32'(m_hit()));
            chk("rdata", rdata, exp_rd());
        end

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w);
        addr = a;
        wdata = d;
        we = w;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(32'h0, 32'h0, 1'b0);
    endtask

    task automatic read_status(input string name, input logic [31:0] exp);
        addr = BASE + 32'd4;
        we = 1'b0;
        @(negedge clk);
        chk(name, rdata, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic oob(input string name, input logic [31:0] a, input logic w);
        addr = a;
        wdata = 32'h0000_00FF;
        we = w;
        @(negedge clk);
        chk({name, "_hit"}, 32'(hit), 32'h0);
        chk({name, "_rd"}, rdata, 32'h0);
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    function automatic int find_start(input int from);
        for (int k = (from < 1 ? 1 : from); k < cyc && k < 8192; k++)
            if (txh[k] === 1'b0 && txh[k-1] === 1'b1) return k;
        return -1;
    endfunction

    function automatic logic [7:0] decode(input int s);
        logic [7:0] b = '0;
        for (int i = 0; i < 8; i++)
            if (s >= 0 && s + C*(1+i) + 1 < 8192) b[i] = txh[s + C*(1+i) + 1];
        return b;
    endfunction

    initial begin
        int n0, s, s2, s3, sel;
        logic [9:0] f;
        logic [31:0] a;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            chk("rst_tx", 32'(tx), 32'h1);
            chk("rst_busy", 32'(busy), 32'h0);
            read_status("rst_status", 32'h0000_0002);
        end

        drive(BASE, 32'h0000_00A5, 1'b1);
        n0 = cyc;
        idle(45);
        s = find_start(n0);
        chk("a5_start", 32'(s), 32'(n0 + 1));
        f = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10; i++) begin
            chk("a5_bit_lo", 32'(txh[n0 + 1 + C*i]), 32'(f[i]));
            chk("a5_bit_hi", 32'(txh[n0 + C*i + C]), 32'(f[i]));
        end
        chk("a5_busy_last", 32'(bh[n0 + 40]), 32'h1);
        chk("a5_busy_drop", 32'(bh[n0 + 41]), 32'h0);

        drive(BASE, 32'h11, 1'b1);
        n0 = cyc;
        drive(BASE, 32'h22, 1'b1);
        drive(BASE, 32'h33, 1'b1);
        read_status("cnt2_status", 32'h0000_0024);
        idle(130);
        s = find_start(n0);
        s2 = find_start(s + 40);
        s3 = find_start(s2 + 40);
        chk("f1_start", 32'(s), 32'(n0 + 1));
        chk("f2_gap", 32'(s2 - s), 32'd41);
        chk("f3_gap", 32'(s3 - s2), 32'd41);
        chk("f1_byte", 32'(decode(s)), 32'h11);
        chk("f2_byte", 32'(decode(s2)), 32'h22);
        chk("f3_byte", 32'(decode(s3)), 32'h33);

        for (int i = 0; i < 6; i++) drive(BASE, 32'(8'h40 + i), 1'b1);
        read_status("ovf_status", 32'h0000_004D);
        drive(BASE + 32'd4, 32'h8, 1'b1);
        read_status("ovf_clear", 32'h0000_0045);
        idle(220);
        read_status("drained", 32'h0000_0002);

        drive(BASE, 32'h5A, 1'b1);
        n0 = cyc;
        drive(BASE, 32'hC3, 1'b1);
        while (cyc < n0 + 1 + 17) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_busy", 32'(busy), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_tx", 32'(tx), 32'h1);
        chk("async_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        read_status("rst_fifo_empty", 32'h0000_0002);
        drive(BASE, 32'h3C, 1'b1);
        n0 = cyc;
        idle(45);
        s = find_start(n0);
        chk("post_rst_start", 32'(s), 32'(n0 + 1));
        chk("post_rst_byte", 32'(decode(s)), 32'h3C);
        chk("post_rst_stop", 32'(txh[n0 + 1 + 9*C + 1]), 32'h1);

        oob("st_base8", BASE + 32'd8, 1'b1);
        oob("ld_base8", BASE + 32'd8, 1'b0);
        oob("st_basem4", BASE - 32'd4, 1'b1);
        oob("ld_basem4", BASE - 32'd4, 1'b0);
        read_status("oob_status", 32'h0000_0002);

        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 9));
            a = sel < 8 ? BASE + 32'(sel) : sel == 8 ? BASE + 32'd8 + 32'($urandom_range(0, 7)) : $urandom;
            drive(a, $urandom, ((i / 500) % 2 == 0) && $urandom_range(0, 99) < 25);
        end
        idle(50);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/riscv_mmio_uart_tx.md
Name: riscv_mmio_uart_tx

Overview:
Memory-mapped UART transmitter that sits on the MEM stage of the 5-stage pipeline, beside data memory. It answers processor stores and loads to its address window. It serialises the stored bytes onto a single tx line as 8N1 frames, using a small FIFO so that the CPU never stalls. It gives testbenches and software a console output path, in the opposite direction to the bench's passive monitoring.

Parameters:
BASE_ADDR, 32'h1000_0000, word-aligned base of the 8-byte register window
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range is 2 or more
FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2, 2 or more

Ports:
clk  in  1  system clock; everything updates on the rising edge
rst_n  in  1  asynchronous active-low reset
ALU_result_M  in  32  MEM-stage address
WriteData_M  in  32  MEM-stage store data
MemWrite_M  in  1  MEM-stage store strobe
hit_M  out  1  combinational; 1 when ALU_result_M[31:3] == BASE_ADDR[31:3]
ReadData_io  out  32  combinational read data, valid when hit_M=1; otherwise 0
tx  out  1  registered serial output, idle-high
busy  out  1  registered; 1 while a frame is being shifted out

Behaviour:
- Register map (offset = ALU_result_M[2:0]; unaligned offsets alias to the word below):
  - +0 TXDATA (W): MemWrite_M && hit_M pushes WriteData_M[7:0]. Reads return 0.
  - +4 STATUS (R): bit0 full, bit1 empty, bit2 busy, bit3 overflow, bits[7:4] FIFO count (saturates at 15), all other bits 0.
  - +4 STATUS (W): writing WriteData_M[3]=1 clears overflow; other bits are ignored.
- Reset (asynchronous, rst_n=0): tx=1, busy=0, FIFO empty (count 0), overflow=0, FSM in IDLE, all counters 0. Reset mid-frame aborts the frame immediately; tx returns to 1 without waiting for a clock edge.
- Push: accepted when count<FIFO_DEPTH, or when a pop occurs in the same cycle. Otherwise the byte is dropped and overflow is set (sticky).
- Simultaneous push and pop: count is unchanged and both pointers advance.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits.
- FSM states:
  - IDLE: tx=1. If FIFO is non-empty, pop into shift register, set busy=1, go to START, and drive tx=0 from the next edge.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA and drive shreg[0].
  - DATA: send 8 bits LSB first, each held CLKS_PER_BIT cycles. A 3-bit bit counter runs 0..7, and the shift register shifts right at each bit boundary. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE with busy=0. If the FIFO is non-empty, pop again in that same IDLE cycle (one idle cycle between frames).
- Baud counter counts 0..CLKS_PER_BIT-1 and reloads at each bit boundary.
- Latency:
  - Store at edge N gives count=1 after edge N.
  - Pop at edge N+1, with tx=0 and busy=1 after edge N+1.
  - A frame is 10*CLKS_PER_BIT cycles of tx activity.
  - Back-to-back frame period is 10*CLKS_PER_BIT+1 cycles.
- Loads have no side effects. A push and a STATUS read in the same cycle cannot occur (single MEM port).

Decomposition:
- Shared package riscv_io_pkg holds:
  - UART_BASE_ADDR, TXDATA_OFS=3'h0, STATUS_OFS=3'h4
  - STATUS bit indices (ST_FULL=0, ST_EMPTY=1, ST_BUSY=2, ST_OVF=3, ST_CNT_LSB=4)
  - the FSM state encoding typedef (IDLE, START, DATA, STOP)
- One sub-module, sync_fifo (WIDTH=8, DEPTH=FIFO_DEPTH): push/pop/full/empty/count, with the same clk/rst_n.
- The FSM, baud and bit counters, and the address decode stay in the top module.

Test Plan:
All cases use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- Reset with no stores: tx=1, busy=0, and a STATUS read returns 32'h0000_0002 for 100 cycles.
- Store 0xA5 to BASE+0: tx goes low 2 edges later and stays low 4 cycles. Then bits 1,0,1,0,0,1,0,1 (4 cycles each), then stop=1 for 4 cycles; busy drops after 40 cycles.
- Store 0x11, 0x22, 0x33 on consecutive cycles: three frames decode in order, each 41 cycles apart. STATUS count reads 2 right after the first pop.
- 6 stores on consecutive cycles while IDLE: the first pops, 4 are queued, the 6th is dropped. STATUS=32'h0000_004D (count 4, overflow, busy, full). Writing 0x8 to BASE+4 clears bit3.
- Assert rst_n=0 during DATA bit 3: tx=1 and busy=0 with no clock edge; FIFO is empty afterwards. The next store produces a clean frame.
- Loads and stores to BASE+8 and BASE-4: hit_M=0, ReadData_io=0, and no FIFO change.
